// File: rtl/pipelined_mux_tree.sv
// rtl/pipelined_mux_tree.sv - pipelined N:1 word mux tree with valid/ready backpressure; optional sel_err via PMT_SEL_ERR_EN
module pipelined_mux_tree #(
    parameter int DATA_W = 8,
    parameter int NUM_IN = 64,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
`ifdef PMT_SEL_ERR_EN
    output logic                     sel_err,
`endif
    output logic [SEL_W-1:0]         out_sel
);

    localparam int LEAVES = 1 << SEL_W;

`ifdef PMT_SEL_ERR_EN
    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W+1)'(NUM_IN);
`endif

    logic                     advance;
    logic [LEAVES*DATA_W-1:0] leaves;

    // The whole pipe moves together; it only freezes when a finished result is refused
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Pad the input vector to a full binary tree; unused leaves are constant zero
    always_comb begin
        leaves = '0;
        leaves[NUM_IN*DATA_W-1:0] = in_data;
    end

    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int NODES = 1 << (SEL_W - k - 1);

        logic [2*NODES*DATA_W-1:0] prev_data;
        logic [SEL_W-1:0]          prev_sel;
        logic                      prev_valid;
        logic [NODES*DATA_W-1:0]   node;
        logic [NODES*DATA_W-1:0]   data_q;
        logic [SEL_W-1:0]          sel_q;
        logic                      valid_q;
`ifdef PMT_SEL_ERR_EN
        logic                      prev_err;
        logic                      err_q;
`endif

        if (k == 0) begin : g_src
            assign prev_data  = leaves;
            assign prev_sel   = in_sel;
            assign prev_valid = in_valid;
`ifdef PMT_SEL_ERR_EN
            assign prev_err   = ({1'b0, in_sel} >= NUM_IN_EXT);
`endif
        end else begin : g_src
            assign prev_data  = g_lvl[k-1].data_q;
            assign prev_sel   = g_lvl[k-1].sel_q;
            assign prev_valid = g_lvl[k-1].valid_q;
`ifdef PMT_SEL_ERR_EN
            assign prev_err   = g_lvl[k-1].err_q;
`endif
        end

        // Level k halves the candidate set using select bit k of the item entering it
        always_comb begin
            node = '0;
            for (int j = 0; j < NODES; j++) begin
                node[j*DATA_W +: DATA_W] = prev_sel[k] ? prev_data[(2*j+1)*DATA_W +: DATA_W]
                                                       : prev_data[2*j*DATA_W +: DATA_W];
            end
        end

        // Stage register: node outputs plus the item's select tag and valid travel together
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                sel_q   <= '0;
                valid_q <= 1'b0;
`ifdef PMT_SEL_ERR_EN
                err_q   <= 1'b0;
`endif
            end else if (advance) begin
                data_q  <= node;
                sel_q   <= prev_sel;
                valid_q <= prev_valid;
`ifdef PMT_SEL_ERR_EN
                err_q   <= prev_err;
`endif
            end
        end
    end

    assign out_valid = g_lvl[SEL_W-1].valid_q;
    assign out_sel   = g_lvl[SEL_W-1].sel_q;

`ifdef PMT_SEL_ERR_EN
    // Out-of-range selects already land on zero padding; the mask keeps that explicit
    assign out_data = g_lvl[SEL_W-1].err_q ? '0 : g_lvl[SEL_W-1].data_q;
    assign sel_err  = g_lvl[SEL_W-1].err_q & out_valid;
`else
    assign out_data = g_lvl[SEL_W-1].data_q;
`endif

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// tb/tb_pipelined_mux_tree.sv - self-checking bench for pipelined_mux_tree (NUM_IN = 64, 5, 2)
module tb_pipelined_mux_tree;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         iv64, ir64, ov64, or64;
    logic [511:0] d64;
    logic [5:0]   is64, os64;
    logic [7:0]   od64;

    logic         iv5, ir5, ov5, or5;
    logic [39:0]  d5;
    logic [2:0]   is5, os5;
    logic [7:0]   od5;

    logic         iv2, ir2, ov2, or2;
    logic [15:0]  d2;
    logic [0:0]   is2, os2;
    logic [7:0]   od2;

`ifdef PMT_SEL_ERR_EN
    logic e64, e5, e2;
`endif

    pipelined_mux_tree #(.DATA_W(8), .NUM_IN(64)) u_n64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_data(d64), .in_sel(is64),
        .out_valid(ov64), .out_ready(or64), .out_data(od64),
`ifdef PMT_SEL_ERR_EN
        .sel_err(e64),
`endif
        .out_sel(os64));

    pipelined_mux_tree #(.DATA_W(8), .NUM_IN(5)) u_n5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_data(d5), .in_sel(is5),
        .out_valid(ov5), .out_ready(or5), .out_data(od5),
`ifdef PMT_SEL_ERR_EN
        .sel_err(e5),
`endif
        .out_sel(os5));

    pipelined_mux_tree #(.DATA_W(8), .NUM_IN(2)) u_n2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(d2), .in_sel(is2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
`ifdef PMT_SEL_ERR_EN
        .sel_err(e2),
`endif
        .out_sel(os2));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] sel;
        logic [7:0] data;
        int         t;
    } item_t;

    item_t q[$];
    bit    nostall;
    bit    last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 64-input instance: drive, check against the expected-item queue, clock
    task automatic step(input logic v, input logic [5:0] s, input logic rd);
        logic exp_rdy;
        iv64 = v;
        is64 = s;
        or64 = rd;
        #1;
        exp_rdy = or64 | ~ov64;
        chk("in_ready", ir64, exp_rdy);
        if (ov64) begin
            chk("no_spurious_valid", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("out_data", od64, q[0].data);
                chk("out_sel", os64, q[0].sel);
                if (rd) begin
                    if (nostall) chk("latency", cyc - q[0].t, 6);
                    void'(q.pop_front());
                end
            end
        end
        last_acc = v && ir64;
        if (last_acc) q.push_back('{sel: s, data: d64[s*8 +: 8], t: cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() != 0; n++) step(1'b0, 6'd0, 1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic       rv;
        logic [5:0] rs;
        rv = 1'b0;
        rs = '0;
        rst = 1'b1;
        iv64 = 0; is64 = 0; or64 = 1; d64 = '0;
        iv5 = 0;  is5 = 0;  or5 = 1;  d5 = '0;
        iv2 = 0;  is2 = 0;  or2 = 1;  d2 = '0;
        nostall = 1'b1;
        last_acc = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", ov64, 0);
        chk("rst_out_data", od64, 0);
        chk("rst_out_sel", os64, 0);
        chk("rst_in_ready", ir64, 1);
        rst = 1'b0;

        // Sweep: every select on consecutive cycles
        for (int i = 0; i < 64; i++) d64[i*8 +: 8] = 8'(i) ^ 8'hA5;
        nostall = 1'b1;
        for (int i = 0; i < 64; i++) step(1'b1, 6'(i), 1'b1);
        drain();

        // Backpressure
        nostall = 1'b0;
        step(1'b1, 6'd5, 1'b1);
        step(1'b1, 6'd17, 1'b1);
        step(1'b1, 6'd42, 1'b1);
        for (int n = 0; n < 10 && !ov64; n++) step(1'b0, 6'd0, 1'b1);
        chk("bp_valid_rose", ov64, 1);
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 6'd0, 1'b0);
            chk("bp_in_ready_low", ir64, 0);
            chk("bp_hold_data", od64, 8'hA0);
            chk("bp_hold_sel", os64, 5);
        end
        drain();

        // Bubbles
        nostall = 1'b1;
        step(1'b1, 6'd3, 1'b1);
        step(1'b0, 6'd0, 1'b1);
        step(1'b0, 6'd0, 1'b1);
        step(1'b1, 6'd60, 1'b1);
        drain();

        // Reset with four items in flight
        for (int i = 0; i < 4; i++) step(1'b1, 6'(i + 7), 1'b1);
        rst = 1'b1;
        iv64 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("mrst_out_valid", ov64, 0);
        chk("mrst_out_data", od64, 0);
        chk("mrst_in_ready", ir64, 1);
        step(1'b1, 6'd1, 1'b1);
        for (int n = 0; n < 5; n++) step(1'b0, 6'd0, 1'b1);
        chk("mrst_new_valid", ov64, 1);
        chk("mrst_new_data", od64, 8'hA4);
        drain();

        // Random traffic with random backpressure
        nostall = 1'b0;
        last_acc = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(rv && !last_acc)) begin
                rv = 1'($urandom_range(0, 1));
                rs = 6'($urandom_range(0, 63));
                for (int i = 0; i < 16; i++) d64[i*32 +: 32] = $urandom();
            end
            step(rv, rs, $urandom_range(0, 3) != 0);
        end
        drain();

        // NUM_IN = 5: three levels, padded leaves
        for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'h10 + 8'(i);
        iv5 = 1'b1;
        is5 = 3'd4;
        #1;
        chk("n5_in_ready", ir5, 1);
        @(posedge clk);
        #1;
        iv5 = 1'b0;
        @(posedge clk);
        #1;
        chk("n5_not_early", ov5, 0);
        @(posedge clk);
        #1;
        chk("n5_valid", ov5, 1);
        chk("n5_data", od5, 8'h14);
        chk("n5_sel", os5, 4);
`ifdef PMT_SEL_ERR_EN
        chk("n5_err_clear", e5, 0);
`endif
        iv5 = 1'b1;
        is5 = 3'd6;
        @(posedge clk);
        #1;
        iv5 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("n5_oor_valid", ov5, 1);
        chk("n5_oor_data", od5, 0);
        chk("n5_oor_sel", os5, 6);
`ifdef PMT_SEL_ERR_EN
        chk("n5_oor_err", e5, 1);
`endif
        @(posedge clk);
        #1;
        chk("n5_idle", ov5, 0);

        // NUM_IN = 2: single level, latency 1, back-to-back
        d2 = {8'h5B, 8'hC3};
        iv2 = 1'b1;
        is2 = 1'b1;
        @(posedge clk);
        #1;
        chk("n2_valid", ov2, 1);
        chk("n2_data", od2, 8'h5B);
        chk("n2_sel", os2, 1);
        for (int i = 0; i < 6; i++) begin
            is2 = 1'(i);
            @(posedge clk);
            #1;
            chk("n2_alt_valid", ov2, 1);
            chk("n2_alt_data", od2, (i % 2) ? 8'h5B : 8'hC3);
        end
        iv2 = 1'b0;
        @(posedge clk);
        #1;
        chk("n2_idle", ov2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
